seg7_time_display: RTL

//  Downstream of the stopwatch core. Takes the core's millisecond time, converts it sequentially to MM.SS.mmm BCD,
//  and time-multiplexes eight active-low seven-segment digits on the board display.

---
 rtl/stopwatch_pkg.sv | 49 ++++
 rtl/time_bcd_converter.sv | 95 +++++++++
 rtl/seg7_time_display.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, converter state encoding and seven-segment encoder
// for the stopwatch display path.
package stopwatch_pkg;

  localparam logic [22:0] MS_PER_MIN = 23'd60000;
  localparam logic [22:0] MS_PER_SEC = 23'd1000;
  localparam logic [22:0] MS_PER_HUN = 23'd100;
  localparam logic [22:0] MS_PER_TEN = 23'd10;
  localparam logic [7:0]  MIN_SAT    = 8'h99;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [3:0]  DIG_BLANK  = 4'hF;

  typedef enum logic [2:0] {
    IDLE, MIN, SEC, HUN, TEN, ONE, SAT, DONE
  } conv_state_e;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } time_bcd_t;

  // Two-digit BCD increment; the ones digit rolls into the tens digit.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_bcd_converter.sv
// Sequential ms -> MM:SS.mmm BCD converter, one subtraction per clock,
// minutes and seconds counted directly in BCD.
module time_bcd_converter
  import stopwatch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [22:0] t_ms_i,
  output logic [27:0] bcd_o,
  output logic        conv_done_o
);

  conv_state_e state_q, state_d;
  logic [22:0] rem_q, rem_d;
  time_bcd_t   bcd_q, bcd_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        rem_d   = t_ms_i;
        bcd_d   = '0;
        state_d = MIN;
      end
      MIN: begin
        if (rem_q >= MS_PER_MIN) begin
          if (bcd_q.min == MIN_SAT) begin
            state_d = SAT;
          end else begin
            rem_d     = rem_q - MS_PER_MIN;
            bcd_d.min = bcd2_inc(bcd_q.min);
          end
        end else begin
          state_d = SEC;
        end
      end
      SEC: begin
        if (rem_q >= MS_PER_SEC) begin
          rem_d     = rem_q - MS_PER_SEC;
          bcd_d.sec = bcd2_inc(bcd_q.sec);
        end else begin
          state_d = HUN;
        end
      end
      HUN: begin
        if (rem_q >= MS_PER_HUN) begin
          rem_d     = rem_q - MS_PER_HUN;
          bcd_d.hun = bcd_q.hun + 4'd1;
        end else begin
          state_d = TEN;
        end
      end
      TEN: begin
        if (rem_q >= MS_PER_TEN) begin
          rem_d     = rem_q - MS_PER_TEN;
          bcd_d.ten = bcd_q.ten + 4'd1;
        end else begin
          state_d = ONE;
        end
      end
      ONE: begin
        bcd_d.one = rem_q[3:0];
        state_d   = DONE;
      end
      SAT: begin
        bcd_d.min = 8'h99;
        bcd_d.sec = 8'h59;
        bcd_d.hun = 4'd9;
        bcd_d.ten = 4'd9;
        bcd_d.one = 4'd9;
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd_o       = bcd_q;
  assign conv_done_o = (state_q == DONE);

endmodule

// File: rtl/seg7_time_display.sv
// Eight-digit multiplexed MM.SS.mmm display with rank digit.
// Optional blink on countdown expiry: define SEG7_BLINK_EN.
module seg7_time_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [22:0] t_ms,
  input  logic [2:0]  rank,
  input  logic        zero,
  output logic        conv_done,
  output logic [7:0]  anode,
  output logic [7:0]  cathode
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [27:0] bcd_raw;
  time_bcd_t   bcd;
  time_bcd_t   disp_q;
  logic [RW-1:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  anode_q, anode_d;
  logic [7:0]  cathode_q, cathode_d;
  logic [7:0]  scan_an;
  logic [3:0]  digit;
  logic        dp;
  logic        blank_d;

  time_bcd_converter u_conv (
    .clk_i       (clock),
    .rst_i       (reset),
    .t_ms_i      (t_ms),
    .bcd_o       (bcd_raw),
    .conv_done_o (conv_done)
  );

  assign bcd = bcd_raw;

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == RW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    digit = DIG_BLANK;
    dp    = 1'b1;
    unique case (idx_q)
      3'd7: digit = disp_q.min[7:4];
      3'd6: begin digit = disp_q.min[3:0]; dp = 1'b0; end
      3'd5: digit = disp_q.sec[7:4];
      3'd4: begin digit = disp_q.sec[3:0]; dp = 1'b0; end
      3'd3: digit = disp_q.hun;
      3'd2: digit = disp_q.ten;
      3'd1: digit = disp_q.one;
      3'd0: digit = (rank == 3'd0) ? DIG_BLANK : {1'b0, rank};
      default: digit = DIG_BLANK;
    endcase
    cathode_d = {dp, seg7_encode(digit)};
    scan_an   = ~(8'b1 << idx_q);
    anode_d   = blank_d ? 8'hFF : scan_an;
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blank_d     = blink_q;
    if (!zero) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blank_d     = ~blink_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blank_d;
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_zero;
  assign unused_zero = zero;
  assign blank_d     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_q    <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      anode_q   <= 8'hFF;
      cathode_q <= 8'hFF;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      if (conv_done) disp_q <= bcd;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule
